// File: rtl/tile_scheduler_pkg.sv
// Raster-wide definitions shared by the tile scheduler: fixed-point format, tile grid, types.
// Pure declarations; no logic, no latency.
// No flow control here; consumers own their handshakes.
package tile_scheduler_pkg;

  // Screen-space fixed point is 12.4 signed.
  localparam int FX_INT_BITS     = 12;
  localparam int FX_FRAC_BITS    = 4;
  localparam int FX_W            = FX_INT_BITS + FX_FRAC_BITS;

  // Tiles are 8x8 pixels on a 40x30 grid.
  localparam int TILE_WIDTH_BITS = 3;
  localparam int TILE_COLUMNS    = 40;
  localparam int TILE_ROWS       = 30;
  localparam int TILE_SHIFT      = FX_FRAC_BITS + TILE_WIDTH_BITS;

  // Tile index widths wide enough for the clamped grid.
  localparam int TX_W = 6;
  localparam int TY_W = 5;

  typedef logic signed [FX_W-1:0] fx_t;

  localparam fx_t FX_ZERO    = '0;
  localparam fx_t TX_LAST_FX = fx_t'(TILE_COLUMNS - 1);
  localparam fx_t TY_LAST_FX = fx_t'(TILE_ROWS - 1);

  localparam logic [TX_W-1:0] TX_LAST = TX_W'(TILE_COLUMNS - 1);
  localparam logic [TY_W-1:0] TY_LAST = TY_W'(TILE_ROWS - 1);

  typedef struct packed {
    fx_t x;
    fx_t y;
    fx_t z;
  } coord_3d_t;

  typedef struct packed {
    logic [15:0]     tri_id;
    logic [7:0]      material;
    logic [TX_W-1:0] tile_x;
    logic [TY_W-1:0] tile_y;
  } metadata_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BBOX  = 2'd1,
    S_ISSUE = 2'd2
  } sched_state_t;

  // Pixel fixed-point coordinate to (possibly negative) tile index; floor toward -inf.
  function automatic fx_t to_tile(input fx_t c);
    return c >>> TILE_SHIFT;
  endfunction

  function automatic fx_t min3(input fx_t a, input fx_t b, input fx_t c);
    fx_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic fx_t max3(input fx_t a, input fx_t b, input fx_t c);
    fx_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

endpackage

// File: rtl/tile_bbox.sv
// Tile-space bounding box of a triangle: shift to tile indices, cull off-screen, clamp to grid.
// Purely combinational; zero latency.
// No handshake; the caller registers the result when it needs it.
module tile_bbox
  import tile_scheduler_pkg::*;
(
  input  fx_t             x0,
  input  fx_t             y0,
  input  fx_t             x1,
  input  fx_t             y1,
  input  fx_t             x2,
  input  fx_t             y2,
  output logic [TX_W-1:0] min_x,
  output logic [TX_W-1:0] max_x,
  output logic [TY_W-1:0] min_y,
  output logic [TY_W-1:0] max_y,
  output logic            cull
);

  fx_t tmin_x;
  fx_t tmax_x;
  fx_t tmin_y;
  fx_t tmax_y;

  assign tmin_x = min3(to_tile(x0), to_tile(x1), to_tile(x2));
  assign tmax_x = max3(to_tile(x0), to_tile(x1), to_tile(x2));
  assign tmin_y = min3(to_tile(y0), to_tile(y1), to_tile(y2));
  assign tmax_y = max3(to_tile(y0), to_tile(y1), to_tile(y2));

  // Cull on the unclamped box, then clamp; clamped values only matter when not culled.
  always_comb begin
    cull  = (tmax_x < FX_ZERO) || (tmax_y < FX_ZERO) ||
            (tmin_x > TX_LAST_FX) || (tmin_y > TY_LAST_FX);
    min_x = (tmin_x < FX_ZERO)    ? '0      : tmin_x[TX_W-1:0];
    max_x = (tmax_x > TX_LAST_FX) ? TX_LAST : tmax_x[TX_W-1:0];
    min_y = (tmin_y < FX_ZERO)    ? '0      : tmin_y[TY_W-1:0];
    max_y = (tmax_y > TY_LAST_FX) ? TY_LAST : tmax_y[TY_W-1:0];
  end

endmodule

// File: rtl/tile_scheduler.sv
// Walks each accepted triangle's clamped tile bbox in raster order, one tile per downstream handshake.
// First tile valid two cycles after accept (IDLE -> BBOX -> ISSUE); one tile per cycle afterwards.
// Outputs hold while vld_out && !rdy_out; rdy_in stays low until the triangle finishes or is culled.
module tile_scheduler
  import tile_scheduler_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  // upstream
  input  logic      vld_in,
  output logic      rdy_in,
  input  coord_3d_t v0,
  input  coord_3d_t v1,
  input  coord_3d_t v2,
  input  metadata_t in_metadata,
  // downstream tile processor
  output logic      vld_out,
  input  logic      rdy_out,
  output coord_3d_t out_v0,
  output coord_3d_t out_v1,
  output coord_3d_t out_v2,
  output metadata_t out_metadata,
  output logic      out_last,
  // status
  output logic      tri_done,
  output logic      tri_culled
);

  sched_state_t    state_q,      state_d;
  logic            rdy_in_q,     rdy_in_d;
  logic            vld_out_q,    vld_out_d;
  logic            out_last_q,   out_last_d;
  logic            tri_done_q,   tri_done_d;
  logic            tri_culled_q, tri_culled_d;
  coord_3d_t       v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  metadata_t       meta_q,       meta_d;
  logic [TX_W-1:0] min_x_q, min_x_d, max_x_q, max_x_d, cur_x_q, cur_x_d;
  logic [TY_W-1:0] min_y_q, min_y_d, max_y_q, max_y_d, cur_y_q, cur_y_d;

  logic [TX_W-1:0] bb_min_x, bb_max_x;
  logic [TY_W-1:0] bb_min_y, bb_max_y;
  logic            bb_cull;

  logic [TX_W-1:0] nxt_x;
  logic [TY_W-1:0] nxt_y;

  tile_bbox u_bbox (
    .x0    (v0_q.x),
    .y0    (v0_q.y),
    .x1    (v1_q.x),
    .y1    (v1_q.y),
    .x2    (v2_q.x),
    .y2    (v2_q.y),
    .min_x (bb_min_x),
    .max_x (bb_max_x),
    .min_y (bb_min_y),
    .max_y (bb_max_y),
    .cull  (bb_cull)
  );

  // Raster successor of the current tile: x inner, y outer.
  always_comb begin
    nxt_x = cur_x_q + TX_W'(1);
    nxt_y = cur_y_q;
    if (cur_x_q == max_x_q) begin
      nxt_x = min_x_q;
      nxt_y = cur_y_q + TY_W'(1);
    end
  end

  // Next-state and next-output logic for the IDLE -> BBOX -> ISSUE walk.
  always_comb begin
    state_d      = state_q;
    rdy_in_d     = rdy_in_q;
    vld_out_d    = vld_out_q;
    out_last_d   = out_last_q;
    tri_done_d   = 1'b0;
    tri_culled_d = 1'b0;
    v0_d         = v0_q;
    v1_d         = v1_q;
    v2_d         = v2_q;
    meta_d       = meta_q;
    min_x_d      = min_x_q;
    max_x_d      = max_x_q;
    min_y_d      = min_y_q;
    max_y_d      = max_y_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;

    case (state_q)
      S_IDLE: begin
        if (vld_in && rdy_in_q) begin
          v0_d     = v0;
          v1_d     = v1;
          v2_d     = v2;
          meta_d   = in_metadata;
          rdy_in_d = 1'b0;
          state_d  = S_BBOX;
        end
      end

      S_BBOX: begin
        if (bb_cull) begin
          tri_culled_d = 1'b1;
          rdy_in_d     = 1'b1;
          state_d      = S_IDLE;
        end else begin
          min_x_d    = bb_min_x;
          max_x_d    = bb_max_x;
          min_y_d    = bb_min_y;
          max_y_d    = bb_max_y;
          cur_x_d    = bb_min_x;
          cur_y_d    = bb_min_y;
          vld_out_d  = 1'b1;
          // The first tile is also the last when the box is a single tile.
          out_last_d = (bb_min_x == bb_max_x) && (bb_min_y == bb_max_y);
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (vld_out_q && rdy_out) begin
          if (out_last_q) begin
            vld_out_d  = 1'b0;
            out_last_d = 1'b0;
            tri_done_d = 1'b1;
            rdy_in_d   = 1'b1;
            state_d    = S_IDLE;
          end else begin
            cur_x_d    = nxt_x;
            cur_y_d    = nxt_y;
            out_last_d = (nxt_x == max_x_q) && (nxt_y == max_y_q);
          end
        end
      end

      default: begin
        state_d   = S_IDLE;
        rdy_in_d  = 1'b1;
        vld_out_d = 1'b0;
      end
    endcase
  end

  // All scheduler state and registered outputs; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rdy_in_q     <= 1'b1;
      vld_out_q    <= 1'b0;
      out_last_q   <= 1'b0;
      tri_done_q   <= 1'b0;
      tri_culled_q <= 1'b0;
      v0_q         <= '0;
      v1_q         <= '0;
      v2_q         <= '0;
      meta_q       <= '0;
      min_x_q      <= '0;
      max_x_q      <= '0;
      min_y_q      <= '0;
      max_y_q      <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
    end else begin
      state_q      <= state_d;
      rdy_in_q     <= rdy_in_d;
      vld_out_q    <= vld_out_d;
      out_last_q   <= out_last_d;
      tri_done_q   <= tri_done_d;
      tri_culled_q <= tri_culled_d;
      v0_q         <= v0_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      meta_q       <= meta_d;
      min_x_q      <= min_x_d;
      max_x_q      <= max_x_d;
      min_y_q      <= min_y_d;
      max_y_q      <= max_y_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
    end
  end

  // Outgoing metadata is the captured triangle metadata with the current tile stamped in.
  always_comb begin
    out_metadata        = meta_q;
    out_metadata.tile_x = cur_x_q;
    out_metadata.tile_y = cur_y_q;
  end

  assign rdy_in     = rdy_in_q;
  assign vld_out    = vld_out_q;
  assign out_last   = out_last_q;
  assign tri_done   = tri_done_q;
  assign tri_culled = tri_culled_q;
  assign out_v0     = v0_q;
  assign out_v1     = v1_q;
  assign out_v2     = v2_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler: table of triangles with hand-computed tile bboxes,
// plus hand-written stall, mid-issue reset and reset-vs-accept sequences.
module tb_tile_scheduler;
  import tile_scheduler_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      vld_in;
  logic      rdy_in;
  coord_3d_t v0, v1, v2;
  metadata_t in_metadata;
  logic      vld_out;
  logic      rdy_out;
  coord_3d_t out_v0, out_v1, out_v2;
  metadata_t out_metadata;
  logic      out_last;
  logic      tri_done;
  logic      tri_culled;

  tile_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .vld_in       (vld_in),
    .rdy_in       (rdy_in),
    .v0           (v0),
    .v1           (v1),
    .v2           (v2),
    .in_metadata  (in_metadata),
    .vld_out      (vld_out),
    .rdy_out      (rdy_out),
    .out_v0       (out_v0),
    .out_v1       (out_v1),
    .out_v2       (out_v2),
    .out_metadata (out_metadata),
    .out_last     (out_last),
    .tri_done     (tri_done),
    .tri_culled   (tri_culled)
  );

  always #5 clk = ~clk;

  // Vertices in whole pixels; expected clamped tile bbox computed by hand (px*16 >>> 7).
  typedef struct {
    int x0, y0, x1, y1, x2, y2;
    int cull;
    int mnx, mxx, mny, mxy;
  } vec_t;

  vec_t tv[10];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic coord_3d_t px(input int x, input int y, input int z);
    coord_3d_t c;
    c.x = fx_t'(x * 16);
    c.y = fx_t'(y * 16);
    c.z = fx_t'(z);
    return c;
  endfunction

  // Offer one triangle and take it through the accepting edge; leaves the DUT in BBOX.
  task automatic offer(input vec_t t, input int id);
    v0                   = px(t.x0, t.y0, id);
    v1                   = px(t.x1, t.y1, id + 1);
    v2                   = px(t.x2, t.y2, id + 2);
    in_metadata.tri_id   = 16'(id);
    in_metadata.material = 8'(id + 3);
    in_metadata.tile_x   = '1;
    in_metadata.tile_y   = '1;
    vld_in               = 1'b1;
    chk("rdy_in_before_accept", int'(rdy_in), 1);
    tick();
    vld_in = 1'b0;
    chk("rdy_in_dropped", int'(rdy_in), 0);
    chk("vld_out_in_bbox", int'(vld_out), 0);
  endtask

  // Full triangle with rdy_out high, optionally stalling stall_n cycles on tile number stall_at.
  task automatic run(input vec_t t, input int id, input int stall_at, input int stall_n);
    int k;
    rdy_out = 1'b1;
    offer(t, id);
    tick();
    if (t.cull != 0) begin
      chk("culled_pulse", int'(tri_culled), 1);
      chk("culled_no_vld", int'(vld_out), 0);
      chk("culled_rdy_in", int'(rdy_in), 1);
      chk("culled_no_done", int'(tri_done), 0);
      tick();
      chk("culled_pulse_end", int'(tri_culled), 0);
      chk("culled_still_no_vld", int'(vld_out), 0);
    end else begin
      k = 0;
      for (int y = t.mny; y <= t.mxy; y++) begin
        for (int x = t.mnx; x <= t.mxx; x++) begin
          chk("tile_vld", int'(vld_out), 1);
          chk("tile_x", int'(out_metadata.tile_x), x);
          chk("tile_y", int'(out_metadata.tile_y), y);
          chk("tile_last", int'(out_last), (x == t.mxx && y == t.mxy) ? 1 : 0);
          chk("tile_tri_id", int'(out_metadata.tri_id), id);
          chk("tile_material", int'(out_metadata.material), id + 3);
          chk("tile_v1x", int'($signed(out_v1.x)), t.x1 * 16);
          chk("tile_no_done", int'(tri_done), 0);
          chk("tile_rdy_in_low", int'(rdy_in), 0);
          if (k == stall_at) begin
            rdy_out = 1'b0;
            for (int s = 0; s < stall_n; s++) begin
              tick();
              chk("stall_vld", int'(vld_out), 1);
              chk("stall_x", int'(out_metadata.tile_x), x);
              chk("stall_y", int'(out_metadata.tile_y), y);
              chk("stall_last", int'(out_last), (x == t.mxx && y == t.mxy) ? 1 : 0);
              chk("stall_v2y", int'($signed(out_v2.y)), t.y2 * 16);
            end
            rdy_out = 1'b1;
          end
          tick();
          k++;
        end
      end
      chk("done_pulse", int'(tri_done), 1);
      chk("done_vld_low", int'(vld_out), 0);
      chk("done_rdy_in", int'(rdy_in), 1);
      chk("done_not_culled", int'(tri_culled), 0);
      tick();
      chk("done_pulse_end", int'(tri_done), 0);
    end
  endtask

  initial begin
    //          x0   y0   x1   y1   x2   y2  cull mnx mxx mny mxy
    tv[0] = '{   1,   1,   5,   2,   3,   6,  0,  0,  0,  0,  0};  // single tile (0,0)
    tv[1] = '{   4,   4,  20,   4,   4,  12,  0,  0,  2,  0,  1};  // 3x2 tiles
    tv[2] = '{ -20, -20, -10,  -5, -15,  -1,  1,  0,  0,  0,  0};  // fully above-left
    tv[3] = '{  -8,  -8, 400,  -8,  -8, 300,  0,  0, 39,  0, 29};  // clamped full screen
    tv[4] = '{ 312, 232, 318, 234, 315, 239,  0, 39, 39, 29, 29};  // bottom-right corner tile
    tv[5] = '{ 320,   0, 330,   0, 325,   5,  1,  0,  0,  0,  0};  // min_x = 40
    tv[6] = '{   0, 240,  10, 240,   5, 250,  1,  0,  0,  0,  0};  // min_y = 30
    tv[7] = '{ -30, 100,  -1, 110,  -5, 120,  1,  0,  0,  0,  0};  // max_x = -1
    tv[8] = '{   7,   7,   8,   8,   7,   8,  0,  0,  1,  0,  1};  // straddles 8px boundary
    tv[9] = '{  -1,  -1,   3,   3,   2,   0,  0,  0,  0,  0,  0};  // min clamped from -1

    rst         = 1'b1;
    vld_in      = 1'b0;
    rdy_out     = 1'b0;
    v0          = '0;
    v1          = '0;
    v2          = '0;
    in_metadata = '0;
    tick();
    tick();
    chk("rst_rdy_in", int'(rdy_in), 1);
    chk("rst_vld_out", int'(vld_out), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_tri_done", int'(tri_done), 0);
    chk("rst_tri_culled", int'(tri_culled), 0);
    chk("rst_out_v0x", int'($signed(out_v0.x)), 0);
    chk("rst_meta", int'(out_metadata), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      run(tv[i], 100 + i, -1, 0);
    end

    // Backpressure: three-cycle stall on tile (1,0) of the 3x2 triangle.
    run(tv[1], 50, 1, 3);

    // Reset while tile (1,1) is pending, with rdy_out high on the same edge.
    rdy_out = 1'b1;
    offer(tv[1], 60);
    tick();
    tick();
    tick();
    tick();
    tick();
    chk("pre_rst_tile_x", int'(out_metadata.tile_x), 1);
    chk("pre_rst_tile_y", int'(out_metadata.tile_y), 1);
    chk("pre_rst_vld", int'(vld_out), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_vld", int'(vld_out), 0);
    chk("mid_rst_rdy_in", int'(rdy_in), 1);
    chk("mid_rst_no_done", int'(tri_done), 0);
    chk("mid_rst_meta", int'(out_metadata), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_vld", int'(vld_out), 0);
      chk("post_rst_no_done", int'(tri_done), 0);
    end

    // Reset together with an offered triangle: nothing may be accepted.
    v0     = px(1, 1, 0);
    v1     = px(5, 2, 0);
    v2     = px(3, 6, 0);
    vld_in = 1'b1;
    rst    = 1'b1;
    tick();
    rst    = 1'b0;
    vld_in = 1'b0;
    chk("rst_vs_accept_rdy_in", int'(rdy_in), 1);
    chk("rst_vs_accept_vld", int'(vld_out), 0);
    tick();
    chk("rst_vs_accept_no_issue", int'(vld_out), 0);
    chk("rst_vs_accept_no_cull", int'(tri_culled), 0);

    // Scheduler is usable again after the resets.
    run(tv[8], 70, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
